// File: rtl/pipeline_control_unit.sv
// Pipeline hazard controller: per-register pending-write scoreboard, stall/flush FSM
// and saturating stall/flush event counters for a 5-stage in-order pipeline.
`default_nettype none

module pipeline_control_unit #(
  parameter int NREGS = 16,
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic             id_writes_i,
  input  logic [RA_W-1:0]  id_dest_i,
  input  logic             id_srcA_used_i,
  input  logic             id_srcB_used_i,
  input  logic [RA_W-1:0]  id_srcA_i,
  input  logic [RA_W-1:0]  id_srcB_i,
  input  logic             ex_jump_taken_i,
  input  logic             wb_we_i,
  input  logic [RA_W-1:0]  wb_addr_i,
  output logic             pc_enable_o,
  output logic             if_id_enable_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       pend_q [NREGS];
  logic [1:0]       pend_d [NREGS];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             src_a_busy, src_b_busy;
  logic             hazard;
  logic             issue;
  logic             stall_evt;
  logic [NREGS-1:0] inc_v, dec_v;

  // Hazard looks only at registered pend so a WB clear releases the stall one cycle later.
  assign src_a_busy = id_srcA_used_i && (pend_q[id_srcA_i] != 2'd0);
  assign src_b_busy = id_srcB_used_i && (pend_q[id_srcB_i] != 2'd0);
  assign hazard     = id_valid_i && (src_a_busy || src_b_busy);
  assign issue      = id_valid_i && !hazard && !ex_jump_taken_i && (state_q != FLUSH);
  assign stall_evt  = hazard && !ex_jump_taken_i && (state_q != FLUSH);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NREGS; i++) begin
      inc_v[i] = issue && id_writes_i && (id_dest_i == RA_W'(i));
      dec_v[i] = wb_we_i && (wb_addr_i == RA_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pend_d[i] = pend_q[i];
      if (inc_v[i] && !dec_v[i] && (pend_q[i] != 2'd3)) begin
        pend_d[i] = pend_q[i] + 2'd1;
      end else if (dec_v[i] && !inc_v[i] && (pend_q[i] != 2'd0)) begin
        pend_d[i] = pend_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    state_d = RUN;
    if (ex_jump_taken_i) begin
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      state_d = RUN;
    end else if (hazard) begin
      state_d = STALL;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ex_jump_taken_i && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // Reset holds the front end frozen with bubbles; a jump outranks every other condition.
  always_comb begin
    pc_enable_o    = 1'b1;
    if_id_enable_o = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = !issue;
    if (!rst_n) begin
      pc_enable_o    = 1'b0;
      if_id_enable_o = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (ex_jump_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (state_q == FLUSH) begin
      id_ex_bubble_o = 1'b1;
    end else if (hazard) begin
      pc_enable_o    = 1'b0;
      if_id_enable_o = 1'b0;
      id_ex_bubble_o = 1'b1;
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
  assign state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: a reference model pushes expected
// control outputs and post-edge state per cycle; monitors pop and compare.
`default_nettype none

module tb_pipeline_control_unit;

  localparam int NREGS = 16;
  localparam int RA_W  = 4;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             id_valid_i, id_writes_i, id_srcA_used_i, id_srcB_used_i;
  logic [RA_W-1:0]  id_dest_i, id_srcA_i, id_srcB_i, wb_addr_i;
  logic             ex_jump_taken_i, wb_we_i;
  logic             pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_bubble_o;
  logic [CNT_W-1:0] stall_count_o, flush_count_o;
  logic [1:0]       state_o;

  pipeline_control_unit #(.NREGS(NREGS), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid_i      (id_valid_i),
    .id_writes_i     (id_writes_i),
    .id_dest_i       (id_dest_i),
    .id_srcA_used_i  (id_srcA_used_i),
    .id_srcB_used_i  (id_srcB_used_i),
    .id_srcA_i       (id_srcA_i),
    .id_srcB_i       (id_srcB_i),
    .ex_jump_taken_i (ex_jump_taken_i),
    .wb_we_i         (wb_we_i),
    .wb_addr_i       (wb_addr_i),
    .pc_enable_o     (pc_enable_o),
    .if_id_enable_o  (if_id_enable_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .stall_count_o   (stall_count_o),
    .flush_count_o   (flush_count_o),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    tag;
    logic [3:0] ctl;   // {pc_enable, if_id_enable, if_id_flush, id_ex_bubble}
    logic [1:0] st;
    int       sc;
    int       fc;
  } exp_t;

  exp_t sb [$];
  exp_t post [$];
  exp_t e_neg, e_pos;

  int n_checks = 0;
  int n_fails  = 0;

  int m_pend [NREGS];
  int m_state, m_sc, m_fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
    m_state = 0;
    m_sc    = 0;
    m_fc    = 0;
  endtask

  // Drive one cycle starting just after a rising edge; returns just after the next edge.
  task automatic drive(input string tag, input bit v, input bit w, input int dest,
                       input bit ua, input int a, input bit ub, input int b,
                       input bit j, input bit we, input int wa);
    exp_t e;
    bit   haz, iss;
    id_valid_i      = v;
    id_writes_i     = w;
    id_dest_i       = RA_W'(dest);
    id_srcA_used_i  = ua;
    id_srcA_i       = RA_W'(a);
    id_srcB_used_i  = ub;
    id_srcB_i       = RA_W'(b);
    ex_jump_taken_i = j;
    wb_we_i         = we;
    wb_addr_i       = RA_W'(wa);

    haz = v && ((ua && m_pend[a] > 0) || (ub && m_pend[b] > 0));
    iss = v && !haz && !j && (m_state != 2);
    e.tag = tag;
    if (j) begin
      e.ctl = 4'b1111; e.st = 2'd2;
      if (m_fc < CMAX) m_fc++;
    end else if (m_state == 2) begin
      e.ctl = 4'b1101; e.st = 2'd0;
    end else if (haz) begin
      e.ctl = 4'b0001; e.st = 2'd1;
      if (m_sc < CMAX) m_sc++;
    end else begin
      e.ctl = {3'b110, !v}; e.st = 2'd0;
    end
    if (iss && w && we && dest == wa) begin
      // same-register issue and write-back cancel out
    end else begin
      if (iss && w && m_pend[dest] < 3) m_pend[dest]++;
      if (we && m_pend[wa] > 0) m_pend[wa]--;
    end
    m_state = e.st;
    e.sc = m_sc;
    e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e_neg = sb.pop_front();
      check({e_neg.tag, ".ctl"},
            {28'd0, pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_bubble_o},
            {28'd0, e_neg.ctl});
      post.push_back(e_neg);
    end
  end

  always @(posedge clk) begin
    #1;
    if (post.size() != 0) begin
      e_pos = post.pop_front();
      check({e_pos.tag, ".state"}, {30'd0, state_o}, {30'd0, e_pos.st});
      check({e_pos.tag, ".stall_cnt"}, 32'(stall_count_o), 32'(e_pos.sc));
      check({e_pos.tag, ".flush_cnt"}, 32'(flush_count_o), 32'(e_pos.fc));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ctl"}, {28'd0, pc_enable_o, if_id_enable_o, if_id_flush_o, id_ex_bubble_o},
          32'b0011);
    check({tag, ".state"}, {30'd0, state_o}, 32'd0);
    check({tag, ".stall_cnt"}, 32'(stall_count_o), 32'd0);
    check({tag, ".flush_cnt"}, 32'(flush_count_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid_i = 0; id_writes_i = 0; id_dest_i = '0; id_srcA_used_i = 0; id_srcA_i = '0;
    id_srcB_used_i = 0; id_srcB_i = '0; ex_jump_taken_i = 0; wb_we_i = 0; wb_addr_i = '0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle("idle");

    // Writer r3, reader stalls 3 cycles, WB in the third stalled cycle releases next cycle
    drive("w3",     1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    drive("r3_s1",  1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    drive("r3_s2",  1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    drive("r3_wb",  1, 0, 0, 1, 3, 0, 0, 0, 1, 3);
    drive("r3_go",  1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    check("gap3.stall_cnt", 32'(stall_count_o), 32'd3);

    // Two writers to r5: stall survives the first WB
    drive("w5a",    1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive("w5b",    1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive("r5_s",   1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    drive("r5_wb1", 1, 0, 0, 0, 0, 1, 5, 0, 1, 5);
    drive("r5_s2",  1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    check("pend5_1.state", {30'd0, state_o}, 32'd1);
    drive("r5_wb2", 1, 0, 0, 0, 0, 1, 5, 0, 1, 5);
    drive("r5_go",  1, 0, 0, 0, 0, 1, 5, 0, 0, 0);

    // Hazard on r2 with a jump in the same cycle
    drive("w2",     1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    drive("r2_jmp", 1, 0, 0, 1, 2, 0, 0, 1, 0, 0);
    check("r2_jmp.state", {30'd0, state_o}, 32'd2);
    check("r2_jmp.flush_cnt", 32'(flush_count_o), 32'd1);
    drive("flush1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

    // Jump-squashed writer to r7 leaves nothing pending
    drive("w7_jmp", 1, 1, 7, 0, 0, 0, 0, 1, 0, 0);
    drive("r7_fl",  1, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    drive("r7_go",  1, 0, 0, 1, 7, 0, 0, 0, 0, 0);

    // Issue and WB on r4 in the same cycle keep pend[4] at 1
    drive("w4",     1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    drive("w4_wb4", 1, 1, 4, 0, 0, 0, 0, 0, 1, 4);
    drive("r4_s",   1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    drive("r4_wb",  1, 0, 0, 1, 4, 0, 0, 0, 1, 4);
    drive("r4_go",  1, 0, 0, 1, 4, 0, 0, 0, 0, 0);

    // Back-to-back jumps keep FLUSH
    drive("jmp_a",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive("jmp_b",  1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    idle("after_jmp");

    for (int k = 0; k < 60; k++) begin
      drive("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom), int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 4; r++) drive("drain", 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
    end

    // Saturate the stall counter on r9, then reset in the middle of the stall
    drive("w9",     1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < (1 << CNT_W) + 5; k++) begin
      drive("sat", 1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    end
    check("sat.stall_cnt", 32'(stall_count_o), 32'(CMAX));
    check("sat.state", {30'd0, state_o}, 32'd1);

    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    #4 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    drive("r9_after", 1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    idle("end");
    #2;

    check("sb_drained", 32'(sb.size() + post.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
